// File: rtl/vga_blit_pkg.sv
// Shared constants for the VRAM blitter: screen geometry, VRAM address layout,
// command modes and FSM state encoding.
package vga_blit_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int VRAM_AW      = 19;
  localparam int VRAM_SEL_BIT = 19;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FILL_WR,
    CP_RD,
    CP_WAIT,
    CP_WR,
    DONE
  } blitState_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Combinational pixel (x,y) to linear VRAM address: y*640 + x, built from
// shifts so no multiplier is needed.
module vram_addr_gen
  import vga_blit_pkg::*;
(
  input  logic [9:0]         x_i,
  input  logic [9:0]         y_i,
  output logic [VRAM_AW-1:0] addr_o
);

  logic [VRAM_AW-1:0] yExt;
  logic [VRAM_AW-1:0] xExt;

  assign yExt   = VRAM_AW'(y_i);
  assign xExt   = VRAM_AW'(x_i);
  assign addr_o = (yExt << 9) + (yExt << 7) + xExt;

endmodule

// File: rtl/avalon_vram_blit_master.sv
// Avalon-MM master drawing rectangles (solid fill or copy) into the 640x480x8 VRAM.
// Copy mode is only built when AVALON_BLIT_COPY_EN is defined; otherwise copy commands are rejected.
module avalon_vram_blit_master
  import vga_blit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [9:0]  i_x0,
  input  logic [9:0]  i_y0,
  input  logic [9:0]  i_src_x,
  input  logic [9:0]  i_src_y,
  input  logic [9:0]  i_w,
  input  logic [9:0]  i_h,
  input  logic [7:0]  i_color,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [19:0] o_address,
  output logic        o_chipselect,
  output logic        o_read,
  output logic        o_write,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata,
  input  logic        i_readdatavalid
);

  blitState_e         state_q;
  logic               mode_q;
  logic [9:0]         x0_q, y0_q, srcX_q, srcY_q, w_q, h_q;
  logic [7:0]         color_q;
  logic [9:0]         cx_q, cy_q;
  logic               busy_q, done_q, error_q;
  logic               write_q, cs_q;
  logic [VRAM_AW-1:0] addr_q;
  logic [7:0]         wdata_q;
`ifdef AVALON_BLIT_COPY_EN
  logic               read_q;
`endif

  logic [9:0]         advCx_d, advCy_d, selCx_d, selCy_d;
  logic               lastPix_d, dstOob_d, srcOob_d;
  logic [VRAM_AW-1:0] dstAddr, srcAddr;

  // Write-accept states address the next pixel; everywhere else the current one.
  always_comb begin
    advCx_d   = cx_q + 10'd1;
    advCy_d   = cy_q;
    if (cx_q == w_q - 10'd1) begin
      advCx_d = 10'd0;
      advCy_d = cy_q + 10'd1;
    end
    lastPix_d = (cx_q == w_q - 10'd1) && (cy_q == h_q - 10'd1);
    selCx_d   = cx_q;
    selCy_d   = cy_q;
    if (state_q == FILL_WR || state_q == CP_WR) begin
      selCx_d = advCx_d;
      selCy_d = advCy_d;
    end
    dstOob_d = (({1'b0, x0_q} + {1'b0, w_q}) > 11'(H_RES)) ||
               (({1'b0, y0_q} + {1'b0, h_q}) > 11'(V_RES));
    srcOob_d = (({1'b0, srcX_q} + {1'b0, w_q}) > 11'(H_RES)) ||
               (({1'b0, srcY_q} + {1'b0, h_q}) > 11'(V_RES));
  end

  vram_addr_gen uDstAddr (
    .x_i    (x0_q + selCx_d),
    .y_i    (y0_q + selCy_d),
    .addr_o (dstAddr)
  );

  vram_addr_gen uSrcAddr (
    .x_i    (srcX_q + selCx_d),
    .y_i    (srcY_q + selCy_d),
    .addr_o (srcAddr)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_FILL;
      x0_q    <= '0;
      y0_q    <= '0;
      srcX_q  <= '0;
      srcY_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef AVALON_BLIT_COPY_EN
      read_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            mode_q  <= i_mode;
            x0_q    <= i_x0;
            y0_q    <= i_y0;
            srcX_q  <= i_src_x;
            srcY_q  <= i_src_y;
            w_q     <= i_w;
            h_q     <= i_h;
            color_q <= i_color;
            cx_q    <= '0;
            cy_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        // Empty beats out-of-bounds, which beats an unsupported mode.
        CHECK: begin
          if (w_q == 10'd0 || h_q == 10'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (dstOob_d || (mode_q == MODE_COPY && srcOob_d)) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= DONE;
`ifdef AVALON_BLIT_COPY_EN
          end else if (mode_q == MODE_COPY) begin
            read_q  <= 1'b1;
            cs_q    <= 1'b1;
            addr_q  <= srcAddr;
            state_q <= CP_RD;
`else
          end else if (mode_q == MODE_COPY) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            write_q <= 1'b1;
            cs_q    <= 1'b1;
            addr_q  <= dstAddr;
            wdata_q <= color_q;
            state_q <= FILL_WR;
          end
        end
        FILL_WR: begin
          if (!i_waitrequest) begin
            if (lastPix_d) begin
              write_q <= 1'b0;
              cs_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cx_q   <= advCx_d;
              cy_q   <= advCy_d;
              addr_q <= dstAddr;
            end
          end
        end
`ifdef AVALON_BLIT_COPY_EN
        CP_RD: begin
          if (!i_waitrequest) begin
            read_q  <= 1'b0;
            cs_q    <= 1'b0;
            state_q <= CP_WAIT;
          end
        end
        CP_WAIT: begin
          if (i_readdatavalid) begin
            wdata_q <= i_readdata[7:0];
            write_q <= 1'b1;
            cs_q    <= 1'b1;
            addr_q  <= dstAddr;
            state_q <= CP_WR;
          end
        end
        CP_WR: begin
          if (!i_waitrequest) begin
            write_q <= 1'b0;
            if (lastPix_d) begin
              cs_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cx_q    <= advCx_d;
              cy_q    <= advCy_d;
              read_q  <= 1'b1;
              addr_q  <= srcAddr;
              state_q <= CP_RD;
            end
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AVALON_BLIT_COPY_EN
  assign o_read = read_q;
  logic unusedRdHigh;
  assign unusedRdHigh = ^i_readdata[31:8];
`else
  assign o_read = 1'b0;
  logic unusedCopyIo;
  assign unusedCopyIo = ^{i_readdata, i_readdatavalid, srcAddr};
`endif

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_address    = {1'b0, addr_q};
  assign o_chipselect = cs_q;
  assign o_write      = write_q;
  assign o_writedata  = {24'b0, wdata_q};

endmodule

// File: doc/avalon_vram_blit_master.md
# avalon_vram_blit_master

Avalon-MM master that draws into the 640x480, 8-bit-per-pixel video memory by issuing bus transactions to the VGA/SRAM slave. It sits on the CPU-side clock domain, alongside the CPU, as a second master on the same bus. It accepts one rectangle command at a time and performs one of two operations:
- solid-colour fill of the rectangle;
- rectangle copy (read source pixel, write destination pixel).

It handles `waitrequest` stalls and `readdatavalid` return.

## Interface
- `H_RES`, 640, horizontal resolution (pixels per line)
- `V_RES`, 480, vertical resolution (lines)
- `i_clk`  in  1  clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  command strobe, sampled only in IDLE
- `i_mode`  in  1  0 = fill, 1 = copy
- `i_x0`, `i_y0`  in  10 each  destination top-left
- `i_src_x`, `i_src_y`  in  10 each  source top-left (copy only)
- `i_w`, `i_h`  in  10 each  rectangle width/height in pixels
- `i_color`  in  8  fill colour
- `o_busy`  out  1  command in progress
- `o_done`  out  1  one-cycle completion pulse
- `o_error`  out  1  one-cycle pulse coincident with `o_done` when command rejected
- `o_address`  out  20  Avalon address; bit 19 always 0 (VRAM space)
- `o_chipselect`  out  1  high whenever `o_read` or `o_write` is high
- `o_read`, `o_write`  out  1 each  Avalon commands
- `o_writedata`  out  32  `{24'b0, pixel}`
- `i_waitrequest`  in  1  slave stall
- `i_readdata`  in  32  only bits [7:0] used
- `i_readdatavalid`  in  1  read data strobe

## Operation
- Reset: all outputs 0, state IDLE, counters 0. Asynchronous reset mid-command aborts immediately; no `o_done` is issued.
- States: IDLE, CHECK, FILL_WR, CP_RD, CP_WAIT, CP_WR, DONE.
- IDLE: on `i_start`, latch all command fields and go to CHECK. `i_start` is ignored in every other state.
- CHECK: evaluate the command in this order:
  - `w==0` or `h==0`: go to DONE with no error.
  - `x0+w>H_RES` or `y0+h>V_RES` (11-bit sums): go to DONE with error. For copy, the same bounds are checked on the source.
  - Otherwise go to FILL_WR or CP_RD according to mode.
- Scan order: raster. Column offset cx runs 0..w-1; on wrap, cx returns to 0 and row offset cy increments. The pixel after (w-1, h-1) ends the command.
- Address: `y*640 + x`, computed as `(y<<9)+(y<<7)+x`. The result is 19 bits, zero-extended to 20.
- FILL_WR:
  - `o_write=1`, `o_writedata={24'b0,color}`.
  - A write is accepted on a cycle with `o_write & ~i_waitrequest`. On acceptance, advance to the next pixel, or go to DONE after the last one.
- Copy:
  - CP_RD: assert `o_read` at the source address until `~i_waitrequest`, then go to CP_WAIT.
  - CP_WAIT: on `i_readdatavalid`, capture `i_readdata[7:0]` and go to CP_WR.
  - CP_WR: write the captured pixel to the destination until accepted, then advance to CP_RD or DONE.
- At most one read is outstanding. `i_readdatavalid` outside CP_WAIT is ignored.
- Stall rule: while `i_waitrequest` is high, `o_address`, `o_read`, `o_write`, `o_writedata` and `o_chipselect` hold stable.
- DONE: pulse `o_done` (and `o_error` if rejected) for one cycle, then return to IDLE.
- Overlapping copy: always executed in forward raster order. Correct results for overlapping source and destination are the caller's responsibility.

## Timing
- All outputs are registered.
- `i_start` at cycle 0: CHECK in cycle 1; first `o_write`/`o_read` high in cycle 2.
- `o_busy` is high from cycle 1 through the DONE cycle, and low in IDLE.
- Fill with zero wait states: one pixel per cycle, so w·h consecutive write cycles. `o_done` follows one cycle after the last accepted write.
- Copy: minimum 3 cycles per pixel (read accepted, data valid, write accepted). Each cycle of `waitrequest` or `readdatavalid` delay adds one cycle.
- Rejected or empty command: `o_done` arrives 2 cycles after `i_start`, with no bus activity.
- A new `i_start` is accepted in the cycle after DONE at the earliest.

## Configuration
- `AVALON_BLIT_COPY_EN` defined: copy mode as described above.
- Not defined:
  - CP_RD, CP_WAIT and CP_WR are not built; `o_read` is tied to 0.
  - `i_mode=1` is rejected in CHECK with `o_error`.
  - Fill behaviour is unchanged.

## Structure
- Shared package `vga_blit_pkg` holds:
  - `H_RES`, `V_RES`;
  - VRAM address width (19) and the VRAM/register select bit (19);
  - mode constants `MODE_FILL=0`, `MODE_COPY=1`;
  - state encoding.
- Sub-module `vram_addr_gen`: combinational x,y to linear address conversion. It is instantiated twice, once for source and once for destination.

## Test plan
- Fill x0=10, y0=2, w=3, h=2, colour 0x5A, zero wait states: 6 writes at addresses 1290, 1291, 1292, 1930, 1931, 1932, each with data 0x5A, on consecutive cycles. `o_done` follows one cycle after the last write.
- Same fill with `i_waitrequest` high for 3 cycles on the second write: outputs are held stable for those 3 cycles, the total is 3 cycles longer, and there are no duplicate writes.
- Copy 2x1 from (0,0) to (100,1) with a slave model returning 0x11 and 0x22 two cycles after each read: reads at 0 and 1; writes 0x11→740 and 0x22→741. Never more than one read outstanding.
- x0=630, w=20: `o_done` and `o_error` both pulse at cycle 2; no `o_write`/`o_read` ever asserted. The same result applies for `i_mode=1` without `AVALON_BLIT_COPY_EN`.
- Reset asserted during the 3rd write of a 4x4 fill: all outputs are 0 immediately and no `o_done`. A new fill after reset starts from its own x0, y0.
- `i_start` pulsed while busy: ignored, and the write count equals the first command's w·h.
